// File: rtl/audio_pkg.sv
// Shared types and constants for the audio stream sequencer.
package audio_pkg;

    localparam int AUDIO_DATA_W = 24;
    localparam int DROP_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ       = 3'd1,
        FILT       = 3'd2,
        WAIT       = 3'd3,
        WRITE_WAIT = 3'd4,
        WRITE      = 3'd5
    } stream_state_t;

endpackage

// File: rtl/audio_stream_ctrl_if.sv
// Signal bundle between the sequencer, the codec FIFOs and the channel filters.
//
// Handshake: read, write and filt_strobe are single-cycle pulses. A pulse
// on read pops one stereo sample that read_ready advertised in the prior
// IDLE cycle. A pulse on write pushes writedata_* and is only issued after
// write_ready was seen high. A pulse on filt_strobe advances the filters by
// exactly one sample, using the held filt_in_* values.
interface audio_stream_ctrl_if
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W
);
    logic              read_ready;
    logic [DATA_W-1:0] readdata_left;
    logic [DATA_W-1:0] readdata_right;
    logic              read;
    logic              write_ready;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic              write;
    logic [DATA_W-1:0] filt_in_left;
    logic [DATA_W-1:0] filt_in_right;
    logic              filt_strobe;
    logic [DATA_W-1:0] filt_out_left;
    logic [DATA_W-1:0] filt_out_right;

    modport master (
        input  read_ready, readdata_left, readdata_right, write_ready,
               filt_out_left, filt_out_right,
        output read, writedata_left, writedata_right, write,
               filt_in_left, filt_in_right, filt_strobe
    );

    modport slave (
        output read_ready, readdata_left, readdata_right, write_ready,
               filt_out_left, filt_out_right,
        input  read, writedata_left, writedata_right, write,
               filt_in_left, filt_in_right, filt_strobe
    );
endinterface

// File: rtl/audio_sample_hold.sv
// Stereo load-enable register pair with synchronous clear.
module audio_sample_hold #(
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o
);
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] right_q;

    // Capture both channels together; otherwise hold the last sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            left_q  <= '0;
            right_q <= '0;
        end else if (load_i) begin
            left_q  <= left_i;
            right_q <= right_i;
        end
    end

    assign left_o  = left_q;
    assign right_o = right_q;
endmodule

// File: rtl/audio_stream_ctrl.sv
// Sequencer: pop one codec sample, strobe the filters once, wait the filter
// latency, push the filtered pair to the codec DAC FIFO.
// Optional feature macro AUDIO_WR_TIMEOUT_EN: drop a sample that waits
// WR_TIMEOUT cycles for write_ready, counting drops in drop_count.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_DATA_W,
    parameter int FILT_LAT   = 1,
    parameter int WR_TIMEOUT = 4096
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    audio_stream_ctrl_if.master   bus,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count,
    output stream_state_t         dbg_state_o
);
    localparam int LAT_W = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;

    if (FILT_LAT < 1) begin : g_bad_filt_lat
        $error("FILT_LAT must be at least 1");
    end
    if (WR_TIMEOUT < 1) begin : g_bad_wr_timeout
        $error("WR_TIMEOUT must be at least 1");
    end

    stream_state_t    state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             load_in;
    logic             load_out;
    logic             wr_expired;

`ifdef AUDIO_WR_TIMEOUT_EN
    localparam int TO_W = $clog2(WR_TIMEOUT + 1);

    logic [TO_W-1:0]       to_cnt_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  drop_evt;

    assign wr_expired = (to_cnt_q == TO_W'(WR_TIMEOUT - 1));
    assign drop_evt   = (state_q == WRITE_WAIT) && !bus.write_ready && wr_expired;

    // Stall timer: runs only while parked in WRITE_WAIT, restarts per sample.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q == WRITE_WAIT) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    // Saturating count of samples abandoned because the DAC FIFO stayed full.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop_evt && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count = drop_q;
`else
    assign wr_expired = 1'b0;
    assign drop_count = '0;
`endif

    // State and filter-latency counter registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic; write_ready wins over an expiring stall timer.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        load_in  = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read_ready) begin
                    load_in = 1'b1;
                    state_d = READ;
                end
            end
            READ: state_d = FILT;
            FILT: begin
                lat_d   = LAT_W'(FILT_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (lat_q == '0) begin
                    load_out = 1'b1;
                    state_d  = WRITE_WAIT;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            WRITE_WAIT: begin
                if (bus.write_ready) begin
                    state_d = WRITE;
                end else if (wr_expired) begin
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pulses and busy are pure state decodes, so they are glitch-free and
    // drop to zero in the cycle right after reset.
    always_comb begin
        bus.read        = (state_q == READ);
        bus.filt_strobe = (state_q == FILT);
        bus.write       = (state_q == WRITE);
        busy            = (state_q != IDLE);
    end

    assign dbg_state_o = state_q;

    audio_sample_hold #(.DATA_W(DATA_W)) u_filt_in_hold (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .load_i  (load_in),
        .left_i  (bus.readdata_left),
        .right_i (bus.readdata_right),
        .left_o  (bus.filt_in_left),
        .right_o (bus.filt_in_right)
    );

    audio_sample_hold #(.DATA_W(DATA_W)) u_writedata_hold (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .load_i  (load_out),
        .left_i  (bus.filt_out_left),
        .right_i (bus.filt_out_right),
        .left_o  (bus.writedata_left),
        .right_o (bus.writedata_right)
    );
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: DUT A (FILT_LAT=1, identity filter)
// and DUT B (FILT_LAT=3, WR_TIMEOUT=8, delayed filter model).
module tb_audio_stream_ctrl;
    import audio_pkg::*;

    localparam int DW = AUDIO_DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    audio_stream_ctrl_if #(.DATA_W(DW)) bus_a ();
    audio_stream_ctrl_if #(.DATA_W(DW)) bus_b ();

    logic                  busy_a, busy_b;
    logic [DROP_CNT_W-1:0] drop_a, drop_b;
    stream_state_t         dbg_state_a, dbg_state_b;

    audio_stream_ctrl #(.DATA_W(DW), .FILT_LAT(1), .WR_TIMEOUT(64)) dut_a (
        .CLOCK_50    (clk),
        .reset       (rst),
        .bus         (bus_a.master),
        .busy        (busy_a),
        .drop_count  (drop_a),
        .dbg_state_o (dbg_state_a)
    );

    audio_stream_ctrl #(.DATA_W(DW), .FILT_LAT(3), .WR_TIMEOUT(8)) dut_b (
        .CLOCK_50    (clk),
        .reset       (rst),
        .bus         (bus_b.master),
        .busy        (busy_b),
        .drop_count  (drop_b),
        .dbg_state_o (dbg_state_b)
    );

    // Identity filter on A.
    assign bus_a.filt_out_left  = bus_a.filt_in_left;
    assign bus_a.filt_out_right = bus_a.filt_in_right;

    // Filter on B: output becomes filt_in + 0x111111 three cycles after the strobe cycle.
    logic sb1, sb2;
    always @(posedge clk) begin
        if (rst) begin
            sb1 <= 1'b0;
            sb2 <= 1'b0;
            bus_b.filt_out_left  <= '0;
            bus_b.filt_out_right <= '0;
        end else begin
            sb1 <= bus_b.filt_strobe;
            sb2 <= sb1;
            if (sb2) begin
                bus_b.filt_out_left  <= bus_b.filt_in_left + 24'h111111;
                bus_b.filt_out_right <= bus_b.filt_in_right + 24'h111111;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags_a();
        return {bus_a.read, bus_a.filt_strobe, bus_a.write, busy_a};
    endfunction

    function automatic logic [3:0] flags_b();
        return {bus_b.read, bus_b.filt_strobe, bus_b.write, busy_b};
    endfunction

    function automatic logic [DW-1:0] smp_l(input int k);
        return 24'h010000 + DW'(k);
    endfunction

    function automatic logic [DW-1:0] smp_r(input int k);
        return 24'hF00000 - DW'(k);
    endfunction

    // {read, filt_strobe, write, busy} for cycles 1..N
    logic [3:0] exp_a1 [6] = '{4'b1001, 4'b0101, 4'b0001, 4'b0001, 4'b0011, 4'b0000};
    logic [3:0] exp_b3 [8] = '{4'b1001, 4'b0101, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0011, 4'b0000};

    initial begin
        int rd, st, wr, bad_per, last_rd, k, idle_cnt, pulses;

        bus_a.read_ready = 1'b0; bus_a.write_ready = 1'b1;
        bus_a.readdata_left = '0; bus_a.readdata_right = '0;
        bus_b.read_ready = 1'b0; bus_b.write_ready = 1'b1;
        bus_b.readdata_left = '0; bus_b.readdata_right = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_eq("rst flags_a", 32'(flags_a()), 32'h0);
        check_eq("rst state_a", 32'(dbg_state_a), 32'(IDLE));
        check_eq("rst wd_l_a", 32'(bus_a.writedata_left), 32'h0);
        check_eq("rst fi_r_a", 32'(bus_a.filt_in_right), 32'h0);
        check_eq("rst drop_a", 32'(drop_a), 32'h0);
        check_eq("rst flags_b", 32'(flags_b()), 32'h0);
        rst = 1'b0;

        // Single sample through A; this cycle is cycle 0
        bus_a.read_ready = 1'b1;
        bus_a.readdata_left = 24'h000100;
        bus_a.readdata_right = 24'hFFFF00;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) bus_a.read_ready = 1'b0;
            check_eq($sformatf("t1 flags c%0d", c), 32'(flags_a()), 32'(exp_a1[c-1]));
            if (c == 1) begin
                check_eq("t1 filt_in_l", 32'(bus_a.filt_in_left), 32'h000100);
                check_eq("t1 filt_in_r", 32'(bus_a.filt_in_right), 32'hFFFF00);
            end
            if (c == 4) begin
                check_eq("t1 wd_l", 32'(bus_a.writedata_left), 32'h000100);
                check_eq("t1 wd_r", 32'(bus_a.writedata_right), 32'hFFFF00);
            end
        end

        // Ten back-to-back samples on A
        rd = 0; st = 0; wr = 0; bad_per = 0; last_rd = 0; k = 0;
        bus_a.read_ready = 1'b1;
        bus_a.readdata_left = smp_l(0);
        bus_a.readdata_right = smp_r(0);
        for (int c = 1; c <= 60; c++) begin
            step();
            if (bus_a.read) begin
                rd++;
                if (rd > 1 && (c - last_rd) != 6) bad_per++;
                last_rd = c;
                k++;
                bus_a.readdata_left = smp_l(k);
                bus_a.readdata_right = smp_r(k);
            end
            if (bus_a.filt_strobe) st++;
            if (bus_a.write) begin
                check_eq($sformatf("t2 wd_l s%0d", wr), 32'(bus_a.writedata_left), 32'(smp_l(wr)));
                check_eq($sformatf("t2 wd_r s%0d", wr), 32'(bus_a.writedata_right), 32'(smp_r(wr)));
                wr++;
            end
        end
        bus_a.read_ready = 1'b0;
        check_eq("t2 reads", 32'(rd), 32'd10);
        check_eq("t2 strobes", 32'(st), 32'd10);
        check_eq("t2 writes", 32'(wr), 32'd10);
        check_eq("t2 period errs", 32'(bad_per), 32'd0);

        // FILT_LAT=3 on B with delayed filter output
        bus_b.read_ready = 1'b1;
        bus_b.readdata_left = 24'h123456;
        bus_b.readdata_right = 24'h0000FF;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 1) bus_b.read_ready = 1'b0;
            check_eq($sformatf("t3 flags c%0d", c), 32'(flags_b()), 32'(exp_b3[c-1]));
            if (c == 5) check_eq("t3 wd_l early", 32'(bus_b.writedata_left), 32'h0);
            if (c == 6) begin
                check_eq("t3 wd_l", 32'(bus_b.writedata_left), 32'h234567);
                check_eq("t3 wd_r", 32'(bus_b.writedata_right), 32'h111210);
            end
        end

        // Back-pressure on A: 50 stalled cycles in WRITE_WAIT
        rd = 0; wr = 0; idle_cnt = 0;
        bus_a.write_ready = 1'b0;
        bus_a.read_ready = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            step();
            if (bus_a.read) rd++;
            if (bus_a.write) wr++;
            if (!busy_a) idle_cnt++;
        end
        bus_a.write_ready = 1'b1;
        check_eq("t4 reads", 32'(rd), 32'd1);
        check_eq("t4 early writes", 32'(wr), 32'd0);
        check_eq("t4 busy drops", 32'(idle_cnt), 32'd0);
        step();
        check_eq("t4 write", 32'(flags_a()), 32'b0011);
        bus_a.read_ready = 1'b0;
        step();
        check_eq("t4 after", 32'(flags_a()), 32'h0);

        // Reset while B is in WAIT
        bus_b.write_ready = 1'b1;
        bus_b.read_ready = 1'b1;
        bus_b.readdata_left = 24'h0A0B0C;
        bus_b.readdata_right = 24'h0C0B0A;
        step();
        bus_b.read_ready = 1'b0;
        repeat (3) step();
        check_eq("t5 in wait", 32'(dbg_state_b), 32'(WAIT));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("t5 flags", 32'(flags_b()), 32'h0);
        check_eq("t5 state", 32'(dbg_state_b), 32'(IDLE));
        check_eq("t5 wd_l", 32'(bus_b.writedata_left), 32'h0);
        check_eq("t5 fi_l", 32'(bus_b.filt_in_left), 32'h0);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus_b.read || bus_b.filt_strobe || bus_b.write) pulses++;
        end
        check_eq("t5 pulses", 32'(pulses), 32'd0);

        // DAC FIFO never ready on B
        wr = 0;
        bus_b.write_ready = 1'b0;
        bus_b.read_ready = 1'b1;
`ifdef AUDIO_WR_TIMEOUT_EN
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) bus_b.read_ready = 1'b0;
            if (bus_b.write) wr++;
            if (c == 13) check_eq("t6 busy last", 32'(busy_b), 32'h1);
        end
        check_eq("t6 state", 32'(dbg_state_b), 32'(IDLE));
        check_eq("t6 drop", 32'(drop_b), 32'd1);
        check_eq("t6 no write", 32'(wr), 32'd0);
        bus_b.read_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) begin
                check_eq("t6 next read", 32'(bus_b.read), 32'h1);
                bus_b.read_ready = 1'b0;
            end
            if (c == 13) bus_b.write_ready = 1'b1;
        end
        check_eq("t6 edge write", 32'(flags_b()), 32'b0011);
        check_eq("t6 drop kept", 32'(drop_b), 32'd1);
        step();
        check_eq("t6 idle", 32'(flags_b()), 32'h0);
`else
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1) bus_b.read_ready = 1'b0;
            if (bus_b.write) wr++;
        end
        check_eq("t6 no write", 32'(wr), 32'd0);
        check_eq("t6 state", 32'(dbg_state_b), 32'(WRITE_WAIT));
        check_eq("t6 drop", 32'(drop_b), 32'd0);
        bus_b.write_ready = 1'b1;
        step();
        check_eq("t6 write", 32'(flags_b()), 32'b0011);
        step();
        check_eq("t6 idle", 32'(flags_b()), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/audio_stream_ctrl.md
# audio_stream_ctrl

Sequencer between the `audio_codec` streaming interface and a pair of per-channel sample filters. It pops one stereo sample from the codec ADC FIFO and presents it to the filters. It strobes the filters exactly once per sample, waits a fixed filter latency, then pushes the filtered pair into the codec DAC FIFO. It replaces ad-hoc `read = read_ready` / `write = write_ready` wiring, so a filter advances once per real sample rather than once per clock.

## Interface
Parameters:
- `DATA_W`, 24, sample width per channel.
- `FILT_LAT`, 1, cycles from the filter strobe cycle to a valid filter output (≥1).
- `WR_TIMEOUT`, 4096, maximum cycles spent in WRITE_WAIT (used only with the macro).

Ports:
- `CLOCK_50`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `read_ready`  in  1  codec ADC FIFO holds a sample.
- `readdata_left`, `readdata_right`  in  DATA_W  codec ADC sample.
- `read`  out  1  one-cycle pop of the codec ADC FIFO.
- `write_ready`  in  1  codec DAC FIFO has space.
- `writedata_left`, `writedata_right`  out  DATA_W  sample to the codec DAC.
- `write`  out  1  one-cycle push to the codec DAC FIFO.
- `filt_in_left`, `filt_in_right`  out  DATA_W  held sample driven to the filters.
- `filt_strobe`  out  1  one-cycle filter advance (filter's `read_ready` input).
- `filt_out_left`, `filt_out_right`  in  DATA_W  filter results.
- `busy`  out  1  high in every state except IDLE.
- `drop_count`  out  16  saturating count of timed-out samples.

## Operation
- FSM states: IDLE, READ, FILT, WAIT, WRITE_WAIT, WRITE. All outputs are registered or decoded from state only.
- IDLE: when `read_ready`=1, load `filt_in_*` ← `readdata_*` and go to READ. Otherwise stay in IDLE.
- READ: `read`=1 for this cycle only; go to FILT.
- FILT: `filt_strobe`=1 for this cycle only; load the latency counter with FILT_LAT−1; go to WAIT.
- WAIT: decrement the counter. At count 0, load `writedata_*` ← `filt_out_*` and go to WRITE_WAIT.
- WRITE_WAIT: if `write_ready`=1, go to WRITE. Otherwise hold.
- WRITE: `write`=1 for this cycle only; go to IDLE.
- Strictly one sample in flight. `read_ready` is ignored outside IDLE, and the codec FIFO absorbs the backlog.
- `writedata_*` and `filt_in_*` hold their last loaded value between samples.
- Arithmetic: data is pass-through only, with no width change. `drop_count` saturates at 16'hFFFF.
- Reset: values as listed under Timing.
- Reset mid-operation: the in-flight sample is discarded and no `read`/`write`/`filt_strobe` pulse is emitted on the cycle after reset.

## Timing
- Reset values: state=IDLE; `read`, `write`, `filt_strobe`, `busy` = 0; `writedata_*`, `filt_in_*`, `drop_count` = 0.
- Cycle numbering: cycle 0 is IDLE with `read_ready`=1.
  - Cycle 1: `read`=1.
  - Cycle 2: `filt_strobe`=1.
  - Cycles 3 … 2+FILT_LAT: WAIT.
  - `writedata_*` is valid from cycle 3+FILT_LAT, which is WRITE_WAIT.
- With `write_ready` already high: `write`=1 in cycle 4+FILT_LAT, and IDLE is re-entered in cycle 5+FILT_LAT.
- Minimum sample period: 5+FILT_LAT cycles, which is 6 at the default.
- A back-to-back sample is accepted in the first IDLE cycle.
- `busy` is high from cycle 1 through the WRITE cycle inclusive.

## Configuration
- `AUDIO_WR_TIMEOUT_EN` defined:
  - WRITE_WAIT counts cycles.
  - After WR_TIMEOUT cycles with `write_ready`=0, the sample is dropped, `drop_count` increments (saturating), and the FSM returns to IDLE without asserting `write`.
  - `write_ready` rising on the timeout cycle itself takes priority: the sample is written and not counted.
- `AUDIO_WR_TIMEOUT_EN` undefined: WRITE_WAIT waits indefinitely, `drop_count` is tied to 0, and no timeout counter is synthesised.

## Structure
- Shared package `audio_pkg`:
  - state enum `stream_state_t`.
  - `AUDIO_DATA_W` = 24.
  - `DROP_CNT_W` = 16.
- Sub-module `audio_sample_hold`: a DATA_W×2 load-enable register pair with synchronous clear. Two instances, one for `filt_in_*` and one for `writedata_*`.
- FSM and counters live in the top.

## Test plan
- Reset, then a single sample L=24'h000100, R=24'hFFFF00, with an identity filter (`filt_out`=`filt_in`) and `write_ready`=1 → pulses `read`@1, `filt_strobe`@2, `write`@5 with `writedata`=24'h000100/24'hFFFF00.
- `read_ready` held high for 10 samples → exactly 10 `read`, 10 `filt_strobe` and 10 `write` pulses, with a period of 6 cycles.
- FILT_LAT=3, and `filt_out` changes only 3 cycles after the strobe → `writedata` equals the new value, and `write` occurs @7.
- `write_ready`=0 for 50 cycles, then 1 → `busy` stays high, there is no second `read`, and `write` occurs one cycle after `write_ready` rises.
- `reset` asserted in WAIT → next cycle IDLE, all outputs 0, no `write` for the aborted sample.
- With `AUDIO_WR_TIMEOUT_EN` and WR_TIMEOUT=8, `write_ready`=0 → sample dropped after 8 cycles, `drop_count`=1, and the next `read_ready` is serviced.
